vdp_super_res_writer: RTL and testbench

- CPU-side VRAM write path for the super-res, super-mid and super-colour display modes.
- Packs sequential CPU byte writes into 32-bit double words with byte enables and queues them in a small FIFO.
- Issues word writes to the VRAM arbiter over a req/ack handshake.
- Uses the same 17-bit double-word address space and byte-lane order (byte 0 = bits 7:0) as the super-res display fetch.

---
 rtl/vdp_super_res_writer.sv | 213 +++++++++++++++++++++
 tb/tb_vdp_super_res_writer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_super_res_writer.sv
// CPU-side VRAM write path for the super-res display modes: packs CPU bytes into double words and queues them for the arbiter.
// Optional idle auto-flush of partial words is enabled by defining SUPER_RES_WRITER_IDLE_FLUSH_EN.
module vdp_super_res_writer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned IDLE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_super,
    input  logic        addr_load,
    input  logic [18:0] addr_in,
    input  logic        data_wr,
    input  logic [7:0]  data_in,
    input  logic        flush,
    output logic        fifo_full,
    output logic        busy,
    output logic        overflow,
    output logic        vram_req,
    output logic [16:0] vram_addr,
    output logic [31:0] vram_wdata,
    output logic [3:0]  vram_be,
    input  logic        vram_ack
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t        state;
    logic [18:0]   ptr;
    logic [31:0]   pack_data;
    logic [3:0]    pack_be;
    logic [16:0]   pack_addr;
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [18:0]   eff_ptr;
    logic [1:0]    lane;
    logic          any_be;
    logic          flush_req;
    logic          need_old;
    logic          need_new;
    logic [3:0]    new_be;
    logic [31:0]   new_data;
    logic [16:0]   new_addr;
    logic [1:0]    n_push;
    logic [1:0]    push_cnt;
    logic [CW:0]   room;
    logic          drop;
    logic          pop;
    entry_t        push0;
    entry_t        push1;
    entry_t        next_head;
    logic          idle_hit;

`ifdef SUPER_RES_WRITER_IDLE_FLUSH_EN
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt;

    assign idle_hit = any_be && !data_wr && !addr_load && (idle_cnt == IW'(IDLE_CYCLES - 1));

    // Idle counter; holds at terminal count while the FIFO refuses the flush so it retries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (!vdp_super || data_wr || addr_load) begin
            idle_cnt <= '0;
        end else if (idle_hit && !drop) begin
            idle_cnt <= '0;
        end else if (any_be && !idle_hit) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    logic unused_idle_cfg;
    assign unused_idle_cfg = (IDLE_CYCLES != 0);
    assign idle_hit        = 1'b0;
`endif

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign busy      = (count != '0) || (|pack_be);

    // Packing and push decision: an old word may flush before the byte lands, and the new word may flush after.
    always_comb begin
        eff_ptr   = addr_load ? addr_in : ptr;
        lane      = eff_ptr[1:0];
        any_be    = |pack_be;
        flush_req = flush || idle_hit;
        need_old  = any_be && (addr_load || (data_wr && (eff_ptr[18:2] != pack_addr)));
        new_be    = need_old ? 4'b0000 : pack_be;
        new_data  = need_old ? 32'h0 : pack_data;
        new_addr  = pack_addr;
        if (data_wr) begin
            if (new_be == 4'b0000) begin
                new_addr = eff_ptr[18:2];
            end
            new_be[lane]                   = 1'b1;
            new_data[{lane, 3'b000} +: 8]  = data_in;
        end
        need_new  = (|new_be) && ((data_wr && (lane == 2'd3)) || flush_req);
        n_push    = 2'(need_old) + 2'(need_new);
        pop       = (state == S_REQ) && vram_ack;
        room      = (CW+1)'(FIFO_DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
        drop      = (n_push != 2'd0) && ((CW+1)'(n_push) > room);
        push_cnt  = drop ? 2'd0 : n_push;
        push0     = need_old ? entry_t'{addr: pack_addr, be: pack_be, data: pack_data}
                             : entry_t'{addr: new_addr, be: new_be, data: new_data};
        push1     = entry_t'{addr: new_addr, be: new_be, data: new_data};
        next_head = (count > CW'(1)) ? mem[rd_ptr + AW'(1)] : push0;
    end

    // FIFO storage; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (vdp_super) begin
            if (push_cnt != 2'd0) begin
                mem[wr_ptr] <= push0;
            end
            if (push_cnt == 2'd2) begin
                mem[wr_ptr + AW'(1)] <= push1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            pack_data  <= '0;
            pack_be    <= '0;
            pack_addr  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            vram_req   <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_be    <= '0;
        end else if (!vdp_super) begin
            state      <= S_IDLE;
            ptr        <= '0;
            pack_data  <= '0;
            pack_be    <= '0;
            pack_addr  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            vram_req   <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_be    <= '0;
        end else begin
            // A refused flush freezes pointer and pack register; the offending command is lost.
            if (!drop) begin
                if (data_wr) begin
                    ptr <= eff_ptr + 19'd1;
                end else if (addr_load) begin
                    ptr <= addr_in;
                end
                pack_be   <= need_new ? 4'b0000 : new_be;
                pack_data <= need_new ? 32'h0 : new_data;
                pack_addr <= new_addr;
                wr_ptr    <= wr_ptr + AW'(push_cnt);
                if (addr_load) begin
                    overflow <= 1'b0;
                end
            end else if (data_wr || addr_load) begin
                overflow <= 1'b1;
            end

            count <= count + CW'(push_cnt) - CW'(pop);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        vram_req   <= 1'b1;
                        vram_addr  <= mem[rd_ptr].addr;
                        vram_be    <= mem[rd_ptr].be;
                        vram_wdata <= mem[rd_ptr].data;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (vram_ack) begin
                        if ((count > CW'(1)) || (push_cnt != 2'd0)) begin
                            vram_addr  <= next_head.addr;
                            vram_be    <= next_head.be;
                            vram_wdata <= next_head.data;
                        end else begin
                            vram_req <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Bench for vdp_super_res_writer: directed vector table, multi-cycle corner sequences and a randomized run against a byte-level model.
module tb_vdp_super_res_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vdp_super;
    logic        addr_load;
    logic [18:0] addr_in;
    logic        data_wr;
    logic [7:0]  data_in;
    logic        flush;
    logic        fifo_full;
    logic        busy;
    logic        overflow;
    logic        vram_req;
    logic [16:0] vram_addr;
    logic [31:0] vram_wdata;
    logic [3:0]  vram_be;
    logic        vram_ack;

    vdp_super_res_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vdp_super  (vdp_super),
        .addr_load  (addr_load),
        .addr_in    (addr_in),
        .data_wr    (data_wr),
        .data_in    (data_in),
        .flush      (flush),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .overflow   (overflow),
        .vram_req   (vram_req),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_be    (vram_be),
        .vram_ack   (vram_ack)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [16:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } word_t;

    typedef struct {
        logic [18:0] start;
        int          nbytes;
        logic [31:0] bytes;
        logic        do_flush;
        logic [16:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
    } vec_t;

    // Byte-level reference: four lane slots, a captured word address and a pointer.
    logic [7:0]  m_byte [4];
    logic [3:0]  m_vld;
    logic [16:0] m_addr;
    logic [18:0] m_ptr;
    word_t       exp_q [$];
    bit          mdl_en = 0;
    bit          mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push();
        word_t w;
        if (m_vld != 4'b0000) begin
            w.a  = m_addr;
            w.be = m_vld;
            w.d  = 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (m_vld[i]) w.d = w.d | (32'(m_byte[i]) << (8 * i));
            end
            exp_q.push_back(w);
            m_vld = 4'b0000;
        end
    endfunction

    function automatic void m_apply(input logic al, input logic [18:0] a, input logic dw,
                                    input logic [7:0] d, input logic fl);
        int ln;
        if (al) begin
            m_push();
            m_ptr = a;
        end
        if (dw) begin
            if ((m_vld != 4'b0000) && (m_ptr[18:2] != m_addr)) m_push();
            if (m_vld == 4'b0000) m_addr = m_ptr[18:2];
            ln = int'(m_ptr[1:0]);
            m_byte[ln] = d;
            m_vld[ln]  = 1'b1;
            if (ln == 3) m_push();
            m_ptr = m_ptr + 19'd1;
        end
        if (fl) m_push();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic al, input logic [18:0] a, input logic dw,
                         input logic [7:0] d, input logic fl);
        addr_load = al;
        addr_in   = a;
        data_wr   = dw;
        data_in   = d;
        flush     = fl;
        if (mdl_en) m_apply(al, a, dw, d, fl);
        step();
        addr_load = 1'b0;
        data_wr   = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        vdp_super = 1'b1;
        addr_load = 1'b0;
        addr_in   = '0;
        data_wr   = 1'b0;
        data_in   = '0;
        flush     = 1'b0;
        vram_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (vram_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic expect_word(input string name, input logic [16:0] a, input logic [31:0] d,
                               input logic [3:0] be);
        bit ok;
        wait_req(ok);
        chk({name, "_req"}, 32'(ok), 1);
        chk({name, "_addr"}, 32'(vram_addr), 32'(a));
        chk({name, "_data"}, vram_wdata, d);
        chk({name, "_be"}, 32'(vram_be), 32'(be));
        vram_ack = 1'b1;
        step();
        vram_ack = 1'b0;
    endtask

    // Randomized-phase monitor: a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        word_t w;
        if (mon_en && vram_req && vram_ack) begin
            if (exp_q.size() == 0) begin
                chk("rand_unexpected_req", 32'(vram_addr), 32'h1FFFFFF);
            end else begin
                w = exp_q.pop_front();
                chk("rand_addr", 32'(vram_addr), 32'(w.a));
                chk("rand_data", vram_wdata, w.d);
                chk("rand_be", 32'(vram_be), 32'(w.be));
            end
        end
    end

    vec_t vt [6];

    initial begin
        bit ok;
        int unstable;
        int seen;

        vt[0] = '{19'h00010, 4, 32'h44332211, 1'b0, 17'h00004, 32'h44332211, 4'hF};
        vt[1] = '{19'h00005, 1, 32'h000000AA, 1'b1, 17'h00001, 32'h0000AA00, 4'b0010};
        vt[2] = '{19'h7FFFC, 4, 32'h87654321, 1'b0, 17'h1FFFF, 32'h87654321, 4'hF};
        vt[3] = '{19'h0000A, 2, 32'h0000A55A, 1'b1, 17'h00002, 32'hA55A0000, 4'b1100};
        vt[4] = '{19'h12347, 1, 32'h00000077, 1'b0, 17'h048D1, 32'h77000000, 4'b1000};
        vt[5] = '{19'h00001, 3, 32'h00030201, 1'b0, 17'h00000, 32'h03020100, 4'b1110};

        do_reset();
        chk("rst_req", 32'(vram_req), 0);
        chk("rst_addr", 32'(vram_addr), 0);
        chk("rst_wdata", vram_wdata, 0);
        chk("rst_be", 32'(vram_be), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(overflow), 0);

        for (int v = 0; v < 6; v++) begin
            do_op(1'b1, vt[v].start, 1'b0, 8'h00, 1'b0);
            for (int b = 0; b < vt[v].nbytes; b++) begin
                do_op(1'b0, 19'h0, 1'b1, vt[v].bytes[8*b +: 8], 1'b0);
            end
            if (vt[v].do_flush) do_op(1'b0, 19'h0, 1'b0, 8'h00, 1'b1);
            expect_word($sformatf("vec%0d", v), vt[v].e_addr, vt[v].e_data, vt[v].e_be);
            chk($sformatf("vec%0d_req_low", v), 32'(vram_req), 0);
            chk($sformatf("vec%0d_busy", v), 32'(busy), 0);
        end

        // Pointer wrap across the top of the byte space.
        do_op(1'b1, 19'h7FFFE, 1'b0, 8'h00, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'h01, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'h02, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'h03, 1'b0);
        expect_word("wrap_hi", 17'h1FFFF, 32'h02010000, 4'b1100);
        do_op(1'b0, 19'h0, 1'b0, 8'h00, 1'b1);
        expect_word("wrap_lo", 17'h00000, 32'h00000003, 4'b0001);

        // addr_load with data_wr flushes the old word and lands a lane-3 byte that flushes too.
        do_op(1'b1, 19'h00100, 1'b0, 8'h00, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'h9D, 1'b0);
        do_op(1'b1, 19'h00203, 1'b1, 8'h5C, 1'b0);
        expect_word("sim_old", 17'h00040, 32'h0000009D, 4'b0001);
        expect_word("sim_new", 17'h00080, 32'h5C000000, 4'b1000);
        do_op(1'b1, 19'h00300, 1'b1, 8'h12, 1'b1);
        expect_word("merge_flush", 17'h000C0, 32'h00000012, 4'b0001);
        chk("merge_flush_ovf", 32'(overflow), 0);

        // Overflow: ack held low, 20 sequential bytes from address 0.
        do_reset();
        do_op(1'b1, 19'h0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 20; i++) do_op(1'b0, 19'h0, 1'b1, 8'(i), 1'b0);
        chk("ovf_full", 32'(fifo_full), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            expect_word($sformatf("ovf_w%0d", k), 17'(k),
                        {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, 4'hF);
        end
        vram_ack = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (vram_req) seen++;
            step();
        end
        vram_ack = 1'b0;
        chk("ovf_no_fifth", 32'(seen), 0);
        chk("ovf_full_after", 32'(fifo_full), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        do_op(1'b1, 19'h00400, 1'b0, 8'h00, 1'b0);
        chk("ovf_cleared", 32'(overflow), 0);
        expect_word("ovf_partial", 17'h00004, 32'h00131211, 4'b0111);

        // Backpressure stability, then reset in the middle of a request.
        do_reset();
        do_op(1'b1, 19'h00100, 1'b0, 8'h00, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'hA1, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'hB2, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'hC3, 1'b0);
        do_op(1'b0, 19'h0, 1'b1, 8'hD4, 1'b0);
        wait_req(ok);
        chk("bp_req", 32'(ok), 1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) do_op(1'b0, 19'h0, 1'b1, 8'hE5, 1'b1);
            else step();
            if (!vram_req || vram_addr != 17'h00040 || vram_wdata != 32'hD4C3B2A1 || vram_be != 4'hF)
                unstable++;
        end
        chk("bp_stable", 32'(unstable), 0);
        reset_n = 1'b0;
        #2;
        chk("bp_rst_req", 32'(vram_req), 0);
        chk("bp_rst_busy", 32'(busy), 0);
        step();
        reset_n = 1'b1;
        vram_ack = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (vram_req) seen++;
            step();
        end
        vram_ack = 1'b0;
        chk("bp_rst_no_req", 32'(seen), 0);

        // vdp_super low discards a partial word.
        do_op(1'b1, 19'h00020, 1'b1, 8'h66, 1'b0);
        chk("sup_busy", 32'(busy), 1);
        vdp_super = 1'b0;
        step();
        vdp_super = 1'b1;
        chk("sup_clear", 32'(busy), 0);
        do_op(1'b0, 19'h0, 1'b0, 8'h00, 1'b1);
        step();
        chk("sup_flush_empty", 32'(vram_req), 0);

        // Idle auto-flush behaviour.
        do_reset();
        do_op(1'b1, 19'h0, 1'b1, 8'h5E, 1'b0);
        seen = 0;
        for (int i = 1; i <= 200; i++) begin
            if (vram_req) begin
                seen = i - 1;
                break;
            end
            step();
        end
`ifdef SUPER_RES_WRITER_IDLE_FLUSH_EN
        chk("idle_latency_ok", 32'((seen >= 64) && (seen <= 66)), 1);
        chk("idle_be", 32'(vram_be), 32'(4'b0001));
        vram_ack = 1'b1;
        step();
        vram_ack = 1'b0;
`else
        chk("idle_no_req", 32'(vram_req), 0);
        do_op(1'b0, 19'h0, 1'b0, 8'h00, 1'b1);
        expect_word("idle_manual", 17'h0, 32'h0000005E, 4'b0001);
`endif

        // Randomized run against the byte-level model; ops are spaced so the FIFO cannot fill.
        do_reset();
        m_vld  = 4'b0000;
        m_ptr  = '0;
        m_addr = '0;
        exp_q.delete();
        mdl_en   = 1;
        mon_en   = 1;
        vram_ack = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic [18:0] a;
            logic [7:0]  d;
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 3) == 0) ? 19'h7FFFC + 19'($urandom_range(0, 3)) : 19'($urandom);
            d = 8'($urandom);
            if (r < 55)      do_op(1'b0, a, 1'b1, d, 1'b0);
            else if (r < 70) do_op(1'b1, a, 1'b0, d, 1'b0);
            else if (r < 80) do_op(1'b1, a, 1'b1, d, 1'b0);
            else if (r < 90) do_op(1'b0, a, 1'b0, d, 1'b1);
            else             do_op(1'b0, a, 1'b1, d, 1'b1);
            repeat ($urandom_range(2, 4)) step();
        end
        do_op(1'b0, 19'h0, 1'b0, 8'h00, 1'b1);
        repeat (20) step();
        mon_en = 0;
        mdl_en = 0;
        vram_ack = 1'b0;
        chk("rand_drained", 32'(exp_q.size()), 0);
        chk("rand_ovf", 32'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
